// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divide controller:
//   DIV_WIDTH      - operand/result width of the divider datapath (24)
//   DIV_ZERO_QUOT  - quotient returned for a divide by zero (all ones)
//   div_state_e    - controller FSM states
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 24;

    // Divide-by-zero yields an all-ones quotient (RISC-V style), so software
    // sees -1 for signed and the maximum value for unsigned.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Sequences one divide request from the EX stage through an external
// multi-cycle divider, and short-circuits divide-by-zero without starting it.
//
// Optional feature: define DIV_CTRL_DZ_TRAP_EN to add the dz_o output; a
// zero-divisor result then returns quot_o = rem_o = 0 with dz_o pulsed.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid_i         - divide request, held until res_valid_o
//   req_signed_i        - 1 = two's-complement, 0 = unsigned
//   req_op1_i/op2_i     - dividend / divisor
//   flush_i             - cancels any in-flight divide
//   stall_o             - holds the pipeline while a divide is outstanding
//   res_valid_o         - one-cycle pulse, quot_o/rem_o valid
//   quot_o, rem_o       - registered results, held until the next capture
//   div_start_o         - high while the divider is working on our operands
//   div_signed_o        - latched signedness to the divider
//   div_annul_o         - one-cycle abort of the divider on flush
//   div_op1_o/op2_o     - latched operands to the divider
//   div_quot_i/rem_i    - divider results, valid with div_ready_i
//   div_ready_i         - divider completion strobe
//   dz_o                - (DIV_CTRL_DZ_TRAP_EN only) divide-by-zero flag
// -----------------------------------------------------------------------------
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    input  logic             req_signed_i,
    input  logic [WIDTH-1:0] req_op1_i,
    input  logic [WIDTH-1:0] req_op2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             div_start_o,
    output logic             div_signed_o,
    output logic             div_annul_o,
    output logic [WIDTH-1:0] div_op1_o,
    output logic [WIDTH-1:0] div_op2_o,
    input  logic [WIDTH-1:0] div_quot_i,
    input  logic [WIDTH-1:0] div_rem_i,
`ifdef DIV_CTRL_DZ_TRAP_EN
    output logic             dz_o,
`endif
    input  logic             div_ready_i
);

    div_state_e       state_reg, state_next;
    logic [WIDTH-1:0] op1_reg,  op1_next;
    logic [WIDTH-1:0] op2_reg,  op2_next;
    logic             signed_reg, signed_next;
    logic [WIDTH-1:0] quot_reg, quot_next;
    logic [WIDTH-1:0] rem_reg,  rem_next;
`ifdef DIV_CTRL_DZ_TRAP_EN
    logic             dz_reg,   dz_next;
`endif

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op1_reg    <= '0;
            op2_reg    <= '0;
            signed_reg <= 1'b0;
            quot_reg   <= '0;
            rem_reg    <= '0;
`ifdef DIV_CTRL_DZ_TRAP_EN
            dz_reg     <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            op1_reg    <= op1_next;
            op2_reg    <= op2_next;
            signed_reg <= signed_next;
            quot_reg   <= quot_next;
            rem_reg    <= rem_next;
`ifdef DIV_CTRL_DZ_TRAP_EN
            dz_reg     <= dz_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        op1_next    = op1_reg;
        op2_next    = op2_reg;
        signed_next = signed_reg;
        quot_next   = quot_reg;
        rem_next    = rem_reg;
`ifdef DIV_CTRL_DZ_TRAP_EN
        dz_next     = dz_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    // Operands are latched on every accept; for a zero divisor
                    // the latched dividend becomes the remainder and the
                    // divider simply never sees div_start_o.
                    op1_next    = req_op1_i;
                    op2_next    = req_op2_i;
                    signed_next = req_signed_i;
                    if (req_op2_i != '0) begin
                        state_next = BUSY;
                    end else begin
                        state_next = ZERO;
                    end
                end
            end

            BUSY: begin
                // A flush in the same cycle as div_ready_i discards the result.
                if (flush_i) begin
                    state_next = IDLE;
                end else if (div_ready_i) begin
                    quot_next  = div_quot_i;
                    rem_next   = div_rem_i;
`ifdef DIV_CTRL_DZ_TRAP_EN
                    dz_next    = 1'b0;
`endif
                    state_next = DONE;
                end
            end

            ZERO: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
`ifdef DIV_CTRL_DZ_TRAP_EN
                    quot_next = '0;
                    rem_next  = '0;
                    dz_next   = 1'b1;
`else
                    quot_next = WIDTH'(DIV_ZERO_QUOT);
                    rem_next  = op1_reg;
`endif
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs. The strobes are decoded from the state so that a flush can
    // cancel them in the same cycle; all are forced low while rst is high
    // because the synchronous reset has not yet moved the state.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_o = 1'b0;
        case (state_reg)
            IDLE:    stall_o = req_valid_i && !flush_i;
            BUSY:    stall_o = 1'b1;
            ZERO:    stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
        if (rst) begin
            stall_o = 1'b0;
        end
    end

    assign res_valid_o  = !rst && (state_reg == DONE) && !flush_i;
    assign div_start_o  = !rst && (state_reg == BUSY) && !flush_i;
    assign div_annul_o  = !rst && (state_reg == BUSY) && flush_i;

    assign quot_o       = quot_reg;
    assign rem_o        = rem_reg;
    assign div_op1_o    = op1_reg;
    assign div_op2_o    = op2_reg;
    assign div_signed_o = signed_reg;

`ifdef DIV_CTRL_DZ_TRAP_EN
    assign dz_o = res_valid_o && dz_reg;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Directed bench for div_ctrl with a behavioural multi-cycle divider.
// Expected results are pushed to a scoreboard queue when a request is driven
// and popped when res_valid_o is seen.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

    localparam int W = 24;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid_i;
    logic         req_signed_i;
    logic [W-1:0] req_op1_i;
    logic [W-1:0] req_op2_i;
    logic         flush_i;
    logic         stall_o;
    logic         res_valid_o;
    logic [W-1:0] quot_o;
    logic [W-1:0] rem_o;
    logic         div_start_o;
    logic         div_signed_o;
    logic         div_annul_o;
    logic [W-1:0] div_op1_o;
    logic [W-1:0] div_op2_o;
    logic [W-1:0] div_quot_i;
    logic [W-1:0] div_rem_i;
    logic         div_ready_i;
`ifdef DIV_CTRL_DZ_TRAP_EN
    logic         dz_o;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_signed_i (req_signed_i),
        .req_op1_i    (req_op1_i),
        .req_op2_i    (req_op2_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .res_valid_o  (res_valid_o),
        .quot_o       (quot_o),
        .rem_o        (rem_o),
        .div_start_o  (div_start_o),
        .div_signed_o (div_signed_o),
        .div_annul_o  (div_annul_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_quot_i   (div_quot_i),
        .div_rem_i    (div_rem_i),
`ifdef DIV_CTRL_DZ_TRAP_EN
        .dz_o         (dz_o),
`endif
        .div_ready_i  (div_ready_i)
    );

    // Behavioural divider: ready after div_lat cycles of div_start_o.
    int div_lat = 3;
    int div_cnt = 0;
    int m_a, m_b, m_q, m_r;

    always @(posedge clk) begin
        if (!div_start_o) div_cnt <= 0;
        else              div_cnt <= div_cnt + 1;
    end

    assign div_ready_i = div_start_o && (div_cnt == div_lat);

    always_comb begin
        m_a = div_signed_o ? int'($signed(div_op1_o)) : int'({8'b0, div_op1_o});
        m_b = div_signed_o ? int'($signed(div_op2_o)) : int'({8'b0, div_op2_o});
        m_q = 0;
        m_r = 0;
        if (m_b != 0) begin
            m_q = m_a / m_b;
            m_r = m_a % m_b;
        end
        div_quot_i = m_q[W-1:0];
        div_rem_i  = m_r[W-1:0];
    end

    // Pulse counters used to prove the absence of results/annuls.
    int rv_count    = 0;
    int annul_count = 0;
    always @(posedge clk) begin
        if (res_valid_o) rv_count++;
        if (div_annul_o) annul_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " stall"},     32'(stall_o),      32'd0);
        chk({tag, " res_valid"}, 32'(res_valid_o),  32'd0);
        chk({tag, " quot"},      32'(quot_o),       32'd0);
        chk({tag, " rem"},       32'(rem_o),        32'd0);
        chk({tag, " start"},     32'(div_start_o),  32'd0);
        chk({tag, " signed"},    32'(div_signed_o), 32'd0);
        chk({tag, " annul"},     32'(div_annul_o),  32'd0);
        chk({tag, " op1"},       32'(div_op1_o),    32'd0);
        chk({tag, " op2"},       32'(div_op2_o),    32'd0);
    endtask

    // Drive one request, wait (bounded) for res_valid_o, compare against the
    // scoreboard entry, then release the request.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input string tag);
        exp_t e;
        int   cyc;
        bit   got;
        bit   start_ok;
        e.q   = eq;
        e.r   = er;
        e.lat = (b == '0) ? 2 : div_lat + 2;
        e.dz  = (b == '0);
`ifdef DIV_CTRL_DZ_TRAP_EN
        if (b == '0) begin
            e.q = '0;
            e.r = '0;
        end
`endif
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_signed_i = s;
        req_op1_i    = a;
        req_op2_i    = b;
        sb.push_back(e);
        #1;
        chk({tag, " stall@accept"}, 32'(stall_o), 32'd1);
        got      = 1'b0;
        cyc      = 0;
        start_ok = 1'b1;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (res_valid_o) begin
                got = 1'b1;
                cyc = i;
            end else if (div_start_o !== (b != '0)) begin
                start_ok = 1'b0;
            end
        end
        chk({tag, " completed"}, 32'(got), 32'd1);
        e = sb.pop_front();
        if (got) begin
            chk({tag, " quot"},       32'(quot_o),      32'(e.q));
            chk({tag, " rem"},        32'(rem_o),       32'(e.r));
            chk({tag, " latency"},    32'(cyc),         32'(e.lat));
            chk({tag, " stall@done"}, 32'(stall_o),     32'd0);
            chk({tag, " start@done"}, 32'(div_start_o), 32'd0);
            chk({tag, " start seq"},  32'(start_ok),    32'd1);
`ifdef DIV_CTRL_DZ_TRAP_EN
            chk({tag, " dz"},         32'(dz_o),        32'(e.dz));
`endif
        end
        $display("txn %s: op1=%0h op2=%0h signed=%0d quot=%0h rem=%0h cycles=%0d",
                 tag, a, b, s, quot_o, rem_o, cyc);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk({tag, " pulse width"}, 32'(res_valid_o), 32'd0);
    endtask

    int rv0, an0;

    initial begin
        rst          = 1'b1;
        req_valid_i  = 1'b1;
        req_signed_i = 1'b1;
        req_op1_i    = 24'd9;
        req_op2_i    = 24'd5;
        flush_i      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        $display("txn reset: outputs checked");
        rst         = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk);

        do_div(24'd704, 24'd36, 1'b0, 24'd19, 24'd20, "u704_36");
        do_div(24'hFFFD40, 24'd36, 1'b1, 24'hFFFFED, 24'hFFFFEC, "s-704_36");
        do_div(24'd704, 24'd0, 1'b0, 24'hFFFFFF, 24'd704, "u704_0");
        repeat (3) @(negedge clk);
`ifdef DIV_CTRL_DZ_TRAP_EN
        chk("hold quot", 32'(quot_o), 32'd0);
`else
        chk("hold quot", 32'(quot_o), 32'hFFFFFF);
`endif
        do_div(24'd100, 24'd7, 1'b0, 24'd14, 24'd2, "u100_7");
        do_div(24'd50, 24'd5, 1'b0, 24'd10, 24'd0, "u50_5");

        // Flush five cycles into a long divide.
        div_lat = 10;
        rv0 = rv_count;
        an0 = annul_count;
        @(negedge clk);
        req_valid_i = 1'b1; req_signed_i = 1'b0; req_op1_i = 24'd704; req_op2_i = 24'd36;
        repeat (5) @(negedge clk);
        flush_i = 1'b1; req_valid_i = 1'b0;
        #1;
        chk("flush busy annul", 32'(div_annul_o), 32'd1);
        chk("flush busy start", 32'(div_start_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush busy stall next", 32'(stall_o), 32'd0);
        chk("flush busy annul next", 32'(div_annul_o), 32'd0);
        repeat (12) @(negedge clk);
        chk("flush busy no result", 32'(rv_count - rv0), 32'd0);
        chk("flush busy one annul", 32'(annul_count - an0), 32'd1);
        chk("flush busy quot held", 32'(quot_o), 32'd10);
        $display("txn flush_busy: annuls=%0d results=%0d", annul_count - an0, rv_count - rv0);

        // Flush in the same cycle the divider reports ready: flush wins.
        div_lat = 3;
        rv0 = rv_count;
        @(negedge clk);
        req_valid_i = 1'b1; req_op1_i = 24'd100; req_op2_i = 24'd7;
        repeat (4) @(negedge clk);
        flush_i = 1'b1; req_valid_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush+ready no result", 32'(rv_count - rv0), 32'd0);
        chk("flush+ready quot held", 32'(quot_o), 32'd10);
        chk("flush+ready stall", 32'(stall_o), 32'd0);
        $display("txn flush_ready: results=%0d quot=%0h", rv_count - rv0, quot_o);

        // Flush while in ZERO.
        rv0 = rv_count;
        @(negedge clk);
        req_valid_i = 1'b1; req_op1_i = 24'd7; req_op2_i = 24'd0;
        @(negedge clk);
        flush_i = 1'b1; req_valid_i = 1'b0;
        #1;
        chk("flush zero stall", 32'(stall_o), 32'd1);
        @(negedge clk);
        flush_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush zero no result", 32'(rv_count - rv0), 32'd0);
        chk("flush zero quot held", 32'(quot_o), 32'd10);
        chk("flush zero rem held", 32'(rem_o), 32'd0);
        $display("txn flush_zero: results=%0d", rv_count - rv0);

        // Reset in the middle of a divide, then a normal divide.
        div_lat = 10;
        @(negedge clk);
        req_valid_i = 1'b1; req_op1_i = 24'd704; req_op2_i = 24'd36;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid-busy reset");
        $display("txn mid_busy_reset: outputs checked");
        rst = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("after reset stall", 32'(stall_o), 32'd0);
        div_lat = 3;
        do_div(24'd704, 24'd36, 1'b0, 24'd19, 24'd20, "post-reset u704_36");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
